// File: rtl/feature_pingpong_buffer.sv
// rtl/feature_pingpong_buffer.sv - ping-pong feature frame buffer between AXI-Stream input and accelerator byte read port
//
// Two banks of 2**ADDR_W bytes. One bank fills from the stream while the
// accelerator reads a completed frame from the other.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn           clock, async-assert / sync-release active-low reset
//   s_axis_tdata/tvalid/tready/tlast    feature byte stream in
//   rd_addr, rd_data                    accelerator read port, 1-cycle registered latency
//   consume_start, consume_done         accelerator claims / releases the read bank
//   frame_avail                         read bank holds a complete unclaimed frame
//   err_len, drop_cnt, clear_err        sticky length error, saturating drop count, sync clear
module feature_pingpong_buffer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int FRAME_LEN = 1960
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              consume_start,
    input  logic              consume_done,
    output logic              frame_avail,
    output logic              err_len,
    input  logic              clear_err,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_BUSY    = 2'd3
    } bank_st_e;

    localparam int                DEPTH       = 2 * (2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_PTR    = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   FRAME_LEN_X = (ADDR_W + 1)'(FRAME_LEN);

    // Reset synchronizer: assertion is immediate, release is aligned to the clock.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    bank_st_e          r_st [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_drop;
    logic              r_err_len;
    logic [7:0]        r_drop_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    bank_st_e          w_st_nxt [2];
    logic              w_wr_bank_nxt;
    logic              w_rd_bank_nxt;
    logic [ADDR_W-1:0] w_wptr_nxt;
    logic              w_drop_nxt;
    logic              w_err_evt;
    logic              w_err_nxt;
    logic [7:0]        w_drop_cnt_nxt;
    logic              w_rd_sel;
    logic              w_ready;
    logic              w_beat;
    logic              w_wr_en;

    // DROP mode swallows the tail of an over-long frame regardless of bank state.
    assign w_ready = w_rst_n &&
                     (r_drop || (r_st[r_wr_bank] == ST_EMPTY) || (r_st[r_wr_bank] == ST_FILLING));
    assign w_beat  = s_axis_tvalid && w_ready;
    assign w_wr_en = w_beat && !r_drop;

    always_comb begin
        w_st_nxt[0]    = r_st[0];
        w_st_nxt[1]    = r_st[1];
        w_wr_bank_nxt  = r_wr_bank;
        w_wptr_nxt     = r_wptr;
        w_drop_nxt     = r_drop;
        w_err_evt      = 1'b0;
        w_rd_sel       = r_rd_bank;
        w_err_nxt      = r_err_len;
        w_drop_cnt_nxt = r_drop_cnt;

        // Release first, so a same-cycle start can claim the other bank.
        if (consume_done && (r_st[r_rd_bank] == ST_BUSY)) begin
            w_st_nxt[r_rd_bank] = ST_EMPTY;
            w_rd_sel            = ~r_rd_bank;
        end
        if (consume_start && (r_st[w_rd_sel] == ST_FULL)) begin
            w_st_nxt[w_rd_sel] = ST_BUSY;
        end
        w_rd_bank_nxt = w_rd_sel;

        // The write bank is only ever EMPTY/FILLING here, so it never collides
        // with the bank touched by the consume logic above.
        if (w_beat) begin
            if (r_drop) begin
                if (s_axis_tlast) begin
                    w_drop_nxt = 1'b0;
                end
            end else if (r_wptr != LAST_PTR) begin
                if (s_axis_tlast) begin
                    w_st_nxt[r_wr_bank] = ST_EMPTY;
                    w_wptr_nxt          = '0;
                    w_err_evt           = 1'b1;
                end else begin
                    w_st_nxt[r_wr_bank] = ST_FILLING;
                    w_wptr_nxt          = r_wptr + ADDR_W'(1);
                end
            end else if (s_axis_tlast) begin
                w_st_nxt[r_wr_bank] = ST_FULL;
                w_wptr_nxt          = '0;
                w_wr_bank_nxt       = ~r_wr_bank;
            end else begin
                w_st_nxt[r_wr_bank] = ST_EMPTY;
                w_wptr_nxt          = '0;
                w_err_evt           = 1'b1;
                w_drop_nxt          = 1'b1;
            end
        end

        // A new error in the same cycle as clear_err restarts the count at 1.
        if (clear_err) begin
            w_err_nxt      = 1'b0;
            w_drop_cnt_nxt = 8'd0;
        end
        if (w_err_evt) begin
            w_err_nxt = 1'b1;
            if (w_drop_cnt_nxt != 8'hFF) begin
                w_drop_cnt_nxt = w_drop_cnt_nxt + 8'd1;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_st[0]    <= ST_EMPTY;
            r_st[1]    <= ST_EMPTY;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wptr     <= '0;
            r_drop     <= 1'b0;
            r_err_len  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_st[0]    <= w_st_nxt[0];
            r_st[1]    <= w_st_nxt[1];
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_wptr     <= w_wptr_nxt;
            r_drop     <= w_drop_nxt;
            r_err_len  <= w_err_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    // Single array addressed as {bank, addr}.
    always_ff @(posedge s_axi_aclk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wptr}] <= s_axis_tdata;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_data <= '0;
        end else if ({1'b0, rd_addr} < FRAME_LEN_X) begin
            r_rd_data <= r_mem[{r_rd_bank, rd_addr}];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign s_axis_tready = w_ready;
    assign rd_data       = r_rd_data;
    assign frame_avail   = (r_st[r_rd_bank] == ST_FULL);
    assign err_len       = r_err_len;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_feature_pingpong_buffer.sv
// tb/tb_feature_pingpong_buffer.sv - self-checking bench for feature_pingpong_buffer
module tb_feature_pingpong_buffer;

    localparam int FL    = 1960;
    localparam int TMO   = 20000;
    localparam int EMPTY = 0;
    localparam int FILL  = 1;
    localparam int FULL  = 2;
    localparam int BUSY  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        consume_start;
    logic        consume_done;
    logic        frame_avail;
    logic        err_len;
    logic        clear_err;
    logic [7:0]  drop_cnt;

    logic        rand_mode = 1'b0;
    logic        d_start = 1'b0, d_done = 1'b0, d_clear = 1'b0;
    logic [10:0] d_addr = 11'd2047;
    logic        r_start = 1'b0, r_done = 1'b0, r_clear = 1'b0;
    logic [10:0] r_addr = 11'd0;
    logic        chk_en = 1'b0;

    int checks = 0;
    int failures = 0;

    assign consume_start = rand_mode ? r_start : d_start;
    assign consume_done  = rand_mode ? r_done  : d_done;
    assign clear_err     = rand_mode ? r_clear : d_clear;
    assign rd_addr       = rand_mode ? r_addr  : d_addr;

    always #5 clk = ~clk;

    feature_pingpong_buffer #(.DATA_W(8), .ADDR_W(11), .FRAME_LEN(FL)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .consume_start (consume_start),
        .consume_done  (consume_done),
        .frame_avail   (frame_avail),
        .err_len       (err_len),
        .clear_err     (clear_err),
        .drop_cnt      (drop_cnt)
    );

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int         m_st [2];
    int         m_wr, m_rd;
    bit         m_drop;
    logic [7:0] q [$];
    logic [7:0] bdat [2][2048];
    int         m_err, m_cnt, m_exp_rd;
    bit         m_vld;
    bit         t_rdy, t_evt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st[0] = EMPTY; m_st[1] = EMPTY;
            m_wr = 0; m_rd = 0; m_drop = 0;
            q.delete();
            m_err = 0; m_cnt = 0; m_exp_rd = 0; m_vld = 1;
        end else begin
            if (int'(rd_addr) >= FL) begin
                m_exp_rd = 0; m_vld = 1;
            end else if (m_st[m_rd] == FULL || m_st[m_rd] == BUSY) begin
                m_exp_rd = int'(bdat[m_rd][rd_addr]); m_vld = 1;
            end else begin
                m_vld = 0;
            end
            t_rdy = m_drop || m_st[m_wr] == EMPTY || m_st[m_wr] == FILL;
            if (consume_done && m_st[m_rd] == BUSY) begin
                m_st[m_rd] = EMPTY;
                m_rd = 1 - m_rd;
            end
            if (consume_start && m_st[m_rd] == FULL) m_st[m_rd] = BUSY;
            t_evt = 0;
            if (s_axis_tvalid && t_rdy) begin
                if (m_drop) begin
                    if (s_axis_tlast) m_drop = 0;
                end else begin
                    q.push_back(s_axis_tdata);
                    m_st[m_wr] = FILL;
                    if (q.size() == FL) begin
                        if (s_axis_tlast) begin
                            for (int k = 0; k < FL; k++) bdat[m_wr][k] = q[k];
                            m_st[m_wr] = FULL;
                            m_wr = 1 - m_wr;
                        end else begin
                            m_st[m_wr] = EMPTY; t_evt = 1; m_drop = 1;
                        end
                        q.delete();
                    end else if (s_axis_tlast) begin
                        m_st[m_wr] = EMPTY; t_evt = 1;
                        q.delete();
                    end
                end
            end
            if (clear_err) begin m_err = 0; m_cnt = 0; end
            if (t_evt) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tready", int'(s_axis_tready), 0);
            chk("rst_frame_avail", int'(frame_avail), 0);
            chk("rst_err_len", int'(err_len), 0);
            chk("rst_drop_cnt", int'(drop_cnt), 0);
            chk("rst_rd_data", int'(rd_data), 0);
        end else if (chk_en) begin
            chk("tready", int'(s_axis_tready),
                int'(m_drop || m_st[m_wr] == EMPTY || m_st[m_wr] == FILL));
            chk("frame_avail", int'(frame_avail), int'(m_st[m_rd] == FULL));
            chk("err_len", int'(err_len), m_err);
            chk("drop_cnt", int'(drop_cnt), m_cnt);
            if (m_vld) chk("rd_data", int'(rd_data), m_exp_rd);
        end
    end

    // ---------------- random consumer ----------------
    always @(posedge clk) begin
        #2;
        r_start = ($urandom_range(0, 29) == 0);
        r_done  = ($urandom_range(0, 49) == 0);
        r_clear = ($urandom_range(0, 1999) == 0);
        r_addr  = 11'($urandom_range(0, 2047));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i % 256);
            1:       return 8'((i + 7) % 256);
            2:       return 8'(255 - (i % 256));
            3:       return 8'((i + 3) % 256);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_frame(input int len, input int last_at, input int kind, input bit gap);
        bit ok;
        int w;
        for (int i = 0; i < len; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pat(kind, i);
            s_axis_tlast  = (i == last_at);
            w = 0;
            do begin
                @(negedge clk);
                ok = s_axis_tready;
                tick();
                w++;
            end while (!ok && w < TMO);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout at %0t: beat %0d not accepted within %0d cycles", $time, i, TMO);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            if (gap && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic pulse(input bit s, input bit d, input bit c);
        d_start = s; d_done = d; d_clear = c;
        tick();
        d_start = 1'b0; d_done = 1'b0; d_clear = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int addr, input int exp);
        d_addr = 11'(addr);
        @(posedge clk);
        @(negedge clk);
        chk(nm, int'(rd_data), exp);
        tick();
    endtask

    task automatic peek(input string nm, input int act_sel, input int exp);
        @(negedge clk);
        case (act_sel)
            0:       chk(nm, int'(s_axis_tready), exp);
            1:       chk(nm, int'(frame_avail), exp);
            2:       chk(nm, int'(err_len), exp);
            default: chk(nm, int'(drop_cnt), exp);
        endcase
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, r;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk_en = 1'b1;

        // first frame into bank0
        send_frame(FL, FL - 1, 0, 1'b0);
        peek("f1_avail", 1, 1);
        peek("f1_tready", 0, 1);
        tick();
        rd_chk("f1_rd0", 0, 8'h00);
        rd_chk("f1_rd5", 5, 8'h05);
        rd_chk("f1_rd1959", 1959, 8'hA7);
        rd_chk("f1_rd2000", 2000, 8'h00);

        // second frame into bank1: both banks occupied
        send_frame(FL, FL - 1, 1, 1'b1);
        peek("both_full_tready", 0, 0);
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        peek("freed_tready", 0, 1);
        peek("freed_avail", 1, 1);
        tick();
        rd_chk("b1_rd0", 0, 7);
        rd_chk("b1_rd1000", 1000, 239);

        // short frame then a good frame into bank0
        send_frame(100, 99, 0, 1'b0);
        peek("short_err", 2, 1);
        peek("short_cnt", 3, 1);
        tick();
        send_frame(FL, FL - 1, 2, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        rd_chk("f3_rd0", 0, 255);
        rd_chk("f3_rd1959", 1959, 88);
        pulse(1'b0, 1'b0, 1'b1);
        peek("clear_err", 2, 0);
        peek("clear_cnt", 3, 0);
        tick();

        // long frame into bank1, then a good frame
        send_frame(2101, 2100, 1, 1'b0);
        peek("long_err", 2, 1);
        peek("long_cnt", 3, 1);
        tick();
        send_frame(FL, FL - 1, 0, 1'b0);

        // consume corner cases
        pulse(1'b0, 1'b1, 1'b0);
        peek("done_on_full_avail", 1, 1);
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        peek("done_start_avail", 1, 0);
        peek("done_start_tready", 0, 1);
        tick();
        rd_chk("f4_rd5", 5, 5);
        pulse(1'b1, 1'b0, 1'b0);
        peek("start_no_avail", 1, 0);
        tick();
        pulse(1'b0, 1'b1, 1'b0);

        // drop counter saturation and clear-vs-error priority
        pulse(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 260; k++) send_frame(1, 0, 0, 1'b0);
        peek("sat_cnt", 3, 255);
        tick();
        d_clear = 1'b1;
        send_frame(1, 0, 0, 1'b0);
        d_clear = 1'b0;
        peek("clr_err_wins_cnt", 3, 1);
        peek("clr_err_wins_err", 2, 1);
        tick();

        // reset mid-frame while the other bank is busy
        send_frame(FL, FL - 1, 2, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        send_frame(1000, -1, 0, 1'b0);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_tready", int'(s_axis_tready), 0);
        chk("arst_err", int'(err_len), 0);
        chk("arst_cnt", int'(drop_cnt), 0);
        chk("arst_rd_data", int'(rd_data), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk_en = 1'b1;
        peek("post_rst_tready", 0, 1);
        tick();
        send_frame(FL, FL - 1, 3, 1'b0);
        rd_chk("post_rst_rd0", 0, 3);
        rd_chk("post_rst_rd1959", 1959, 170);
        rd_chk("post_rst_rd2000", 2000, 0);

        // randomized traffic with a random consumer
        rand_mode = 1'b1;
        for (int f = 0; f < 12; f++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      len = FL;
            else if (r < 85) len = $urandom_range(1, FL - 1);
            else             len = $urandom_range(FL + 1, 2100);
            send_frame(len, len - 1, 4, 1'b1);
        end
        repeat (50) tick();
        rand_mode = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/feature_pingpong_buffer.md
Name: feature_pingpong_buffer

Overview:
Input feature buffer directly upstream of conv_accelerator. Receives 8-bit spectrogram features over AXI4-Stream into two ping-pong banks of 2048 bytes each. Serves the accelerator's byte read port (ram_addr/ram_rdata) from the completed bank while the other bank fills. A frame is 49x40 = 1960 bytes.

Parameters:
DATA_W, 8, feature byte width
ADDR_W, 11, read/write address width per bank (2048 entries)
FRAME_LEN, 1960, bytes per frame; must be <= 2**ADDR_W

Ports:
s_axi_aclk  in  1  system clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_W  feature byte
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accept
s_axis_tlast  in  1  last byte of frame
rd_addr  in  ADDR_W  accelerator read address (connects to ram_addr)
rd_data  out  DATA_W  read data, 1-cycle latency (connects to ram_rdata)
consume_start  in  1  pulse: accelerator starts on the available frame (driven with accel start)
consume_done  in  1  pulse: accelerator finished; release the bank
frame_avail  out  1  read bank holds a complete, unclaimed frame
err_len  out  1  sticky: frame length/tlast mismatch seen
clear_err  in  1  synchronous clear of err_len and drop_cnt
drop_cnt  out  8  saturating count of dropped frames

Behaviour:
- Reset: asynchronous assertion, synchronous release to s_axi_aclk.
- While in reset: both banks EMPTY, wr_bank=0, rd_bank=0, wptr=0, DROP mode off.
- Reset values: rd_data=0, err_len=0, drop_cnt=0, frame_avail=0, s_axis_tready=0.
- Per-bank state: EMPTY, FILLING, FULL, BUSY.
- s_axis_tready is combinational: 1 when out of reset and (bank[wr_bank] is EMPTY or FILLING, or DROP mode is on).
- Accepted beat (tvalid && tready), normal mode:
  - Write tdata to bank[wr_bank][wptr]. Bank becomes FILLING.
  - wptr < FRAME_LEN-1 and tlast=0: wptr++.
  - wptr < FRAME_LEN-1 and tlast=1 (short frame): discard the frame. Bank returns to EMPTY, wptr=0, err_len=1, drop_cnt++.
  - wptr == FRAME_LEN-1 and tlast=1: commit. Bank becomes FULL, wptr=0, wr_bank toggles.
  - wptr == FRAME_LEN-1 and tlast=0 (long frame): discard the frame. Bank returns to EMPTY, wptr=0, err_len=1, drop_cnt++, enter DROP mode.
- DROP mode: accept and discard all beats with tready=1 and no writes. Leave DROP mode on the beat carrying tlast. The next beat starts a new frame at wptr=0.
- frame_avail = (bank[rd_bank] == FULL).
- consume_start with frame_avail=1: bank[rd_bank] becomes BUSY. When frame_avail=0 the pulse is ignored with no error.
- consume_done with bank[rd_bank]==BUSY: bank becomes EMPTY and rd_bank toggles. Otherwise the pulse is ignored.
- consume_start and consume_done in the same cycle: done is applied first, then start is evaluated against the new rd_bank in the same cycle.
- rd_data is registered every cycle, independent of bank state:
  - rd_addr < FRAME_LEN: rd_data = bank[rd_bank][rd_addr], using the rd_bank value sampled that cycle.
  - rd_addr >= FRAME_LEN: rd_data = 0.
- Write and read never target the same bank in the same cycle, because the write bank cannot be FULL or BUSY while being filled. When both banks are FULL/BUSY, tready=0 until consume_done frees a bank.
- tready rises in the cycle after the freeing consume_done.
- drop_cnt saturates at 255.
- clear_err is synchronous. If clear_err and a new error occur in the same cycle, the error wins: err_len=1 and drop_cnt=1.
- Reset asserted mid-frame or mid-consume: the in-flight frame is lost, with no err_len or drop_cnt effect.
- Memory: two 2048x8 arrays, or one 4096x8 array addressed as {bank, addr}. Both forms must infer block RAM: write port synchronous, read port registered.

Test Plan:
- Reset release, stream 1960 bytes (value = i mod 256, tlast on byte 1959) -> frame_avail=1 the cycle after the last beat; tready stays 1; reads of addr 0, 5, 1959 return 0x00, 0x05, 0xA7 one cycle later; addr 2000 returns 0x00.
- Fill bank0 and bank1 without consuming -> tready=0 after the second frame; consume_start then consume_done -> tready=1 the next cycle, frame_avail=1 and reads now return bank1 data.
- Short frame (tlast on byte 99) -> err_len=1, drop_cnt=1, frame_avail=0; the next full 1960-byte frame commits normally from wptr=0.
- Long frame (no tlast by byte 1959; tlast on byte 2100) -> err_len=1, drop_cnt=1, beats 1960..2100 accepted and discarded; the next frame commits.
- consume_done while the bank is FULL (not BUSY) and consume_start while frame_avail=0 -> no state change; simultaneous done+start with both banks FULL -> rd_bank toggles and the new bank becomes BUSY in the same cycle.
- Assert s_axi_aresetn low at byte 1000 of a frame while the other bank is BUSY -> all outputs return to reset values immediately; after release, tready=1 and the first frame is stored at address 0.
